traffic_lights_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of `traffic_lights` and drives its `cmd_type_i`/`cmd_valid_i`/`cmd_data_i` port. A host pushes requests through a valid/ready handshake. The block validates each request and buffers it in a small FIFO. It replays requests as single-cycle command pulses with a guaranteed idle gap between them. Time-setting requests are automatically wrapped in an unregulated-mode entry/exit, so the host never has to sequence modes by hand.

---
 rtl/traffic_lights_cmd_seq.sv | 192 +++++++++++++++++++
 tb/tb_traffic_lights_cmd_seq.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lights_cmd_seq.sv
// Command sequencer feeding traffic_lights: validates and buffers host requests,
// then replays them as spaced single-cycle pulses, wrapping time settings in unregulated mode.
module traffic_lights_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_GAP    = 2,
    parameter int MAX_TIME   = 1000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  req_type_i,
    input  logic [15:0] req_data_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    output logic [2:0]  cmd_type_o,
    output logic [15:0] cmd_data_o,
    output logic        cmd_valid_o,
    output logic [1:0]  mode_o,
    output logic [7:0]  drop_cnt_o,
    output logic        busy_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam logic [PTR_W:0]   DEPTH_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CMD_GAP - 1);
    localparam logic [15:0]      TIME_MAX   = 16'(MAX_TIME);
    localparam logic [1:0]       MODE_UNREG = 2'd2;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] data;
    } entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } state_t;

    entry_t           mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [7:0]       drop_reg;

    state_t           state_reg;
    logic [CNT_W-1:0] gap_cnt_reg;
    logic             wrap_reg;
    logic [1:0]       saved_mode_reg;
    logic [1:0]       mode_reg;
    logic             cmd_valid_reg;
    logic [2:0]       cmd_type_reg;
    logic [15:0]      cmd_data_reg;

    logic        accept;
    logic        req_is_time;
    logic        req_ok;
    logic        push;
    logic        drop;
    logic        fifo_empty;
    entry_t      head;
    logic        head_is_time;

    logic        issue;
    logic [2:0]  issue_type;
    logic [15:0] issue_data;
    logic        pop;
    logic        wrap_open;
    logic        wrap_close;

    // Invalid requests are still consumed so the host never stalls on them.
    assign accept      = req_valid_i & req_ready_o;
    assign req_is_time = (req_type_i >= 3'd3) && (req_type_i <= 3'd5);
    assign req_ok      = (req_type_i <= 3'd2) ||
                         (req_is_time && (req_data_i != 16'd0) && (req_data_i <= TIME_MAX));
    assign push        = accept & req_ok;
    assign drop        = accept & ~req_ok;

    assign fifo_empty   = (count_reg == '0);
    assign head         = mem_reg[rd_ptr_reg];
    assign head_is_time = !fifo_empty && (head.kind >= 3'd3);

    always_comb begin
        issue      = 1'b0;
        issue_type = 3'd0;
        issue_data = 16'd0;
        pop        = 1'b0;
        wrap_open  = 1'b0;
        wrap_close = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (head_is_time && !wrap_reg && (mode_reg != MODE_UNREG)) begin
                // Enter unregulated first; the time command stays at the head.
                issue      = 1'b1;
                issue_type = 3'd2;
                wrap_open  = 1'b1;
            end else if (!fifo_empty) begin
                issue      = 1'b1;
                pop        = 1'b1;
                issue_type = head.kind;
                issue_data = head.data;
                wrap_close = !head_is_time;
            end else if (wrap_reg) begin
                issue      = 1'b1;
                issue_type = (saved_mode_reg == 2'd0) ? 3'd0 : 3'd1;
                wrap_close = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= '{kind: req_type_i, data: req_data_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            drop_reg   <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            if (drop && (drop_reg != 8'hFF)) begin
                drop_reg <= drop_reg + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg      <= ST_IDLE;
            gap_cnt_reg    <= '0;
            wrap_reg       <= 1'b0;
            saved_mode_reg <= 2'd0;
            mode_reg       <= 2'd0;
            cmd_valid_reg  <= 1'b0;
            cmd_type_reg   <= 3'd0;
            cmd_data_reg   <= 16'd0;
        end else begin
            cmd_valid_reg <= issue;
            if (issue) begin
                cmd_type_reg <= issue_type;
                cmd_data_reg <= issue_data;
                if (issue_type <= 3'd2) begin
                    mode_reg <= issue_type[1:0];
                end
            end
            if (wrap_open) begin
                wrap_reg       <= 1'b1;
                saved_mode_reg <= mode_reg;
            end else if (wrap_close) begin
                wrap_reg <= 1'b0;
            end
            // The pulse cycle itself is the first GAP cycle; CMD_GAP low cycles follow.
            case (state_reg)
                ST_IDLE: begin
                    if (issue) begin
                        state_reg   <= ST_GAP;
                        gap_cnt_reg <= '0;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o = (count_reg != DEPTH_FULL);
    assign cmd_valid_o = cmd_valid_reg;
    assign cmd_type_o  = cmd_type_reg;
    assign cmd_data_o  = cmd_data_reg;
    assign mode_o      = mode_reg;
    assign drop_cnt_o  = drop_reg;
    assign busy_o      = !fifo_empty || (state_reg != ST_IDLE) || wrap_reg;

endmodule

// File: tb/tb_traffic_lights_cmd_seq.sv
// Bench for traffic_lights_cmd_seq: request-queue reference model checked every cycle,
// a validation vector table, and directed wrap / full-FIFO / reset sequences.
module tb_traffic_lights_cmd_seq;

    localparam int FIFO_DEPTH = 4;
    localparam int CMD_GAP    = 2;
    localparam int MAX_TIME   = 1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  req_type = 3'd0;
    logic [15:0] req_data = 16'd0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  cmd_type;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic [1:0]  mode;
    logic [7:0]  drop_cnt;
    logic        busy;

    always #5 clk = ~clk;

    traffic_lights_cmd_seq #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CMD_GAP   (CMD_GAP),
        .MAX_TIME  (MAX_TIME)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_type_i (req_type),
        .req_data_i (req_data),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .cmd_type_o (cmd_type),
        .cmd_data_o (cmd_data),
        .cmd_valid_o(cmd_valid),
        .mode_o     (mode),
        .drop_cnt_o (drop_cnt),
        .busy_o     (busy)
    );

    typedef struct packed {
        logic [2:0]  t;
        logic [15:0] d;
    } cmd_t;

    typedef struct {
        logic [2:0]  t;
        logic [15:0] d;
        bit          ok;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int edge_n = 0;
    int last_acc = 0;

    // Reference model: accepted requests in a queue, issue times as edge numbers.
    cmd_t        m_q[$];
    logic [1:0]  m_mode;
    logic [1:0]  m_saved;
    bit          m_wrap;
    int          m_last;
    logic [7:0]  m_drop;
    bit          m_valid;
    cmd_t        m_cmd;
    logic [31:0] m_exp;

    cmd_t log_q[$];
    int   log_cyc[$];
    cmd_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit rule_ok(input logic [2:0] t, input logic [15:0] d);
        if (t <= 3'd2) return 1'b1;
        if (t <= 3'd5) return (d != 16'd0) && (int'(d) <= MAX_TIME);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_mode  = 2'd0;
        m_saved = 2'd0;
        m_wrap  = 1'b0;
        m_last  = -1000;
        m_drop  = 8'd0;
        m_valid = 1'b0;
        m_cmd   = '0;
    endtask

    task automatic model_issue(input logic [2:0] t, input logic [15:0] d, input int e);
        m_valid = 1'b1;
        m_cmd.t = t;
        m_cmd.d = d;
        if (t <= 3'd2) m_mode = t[1:0];
        m_last = e;
    endtask

    task automatic model_step(input bit v, input logic [2:0] t, input logic [15:0] d);
        int e;
        bit ready;
        bit busy_m;
        cmd_t c;
        e = edge_n + 1;
        ready = (m_q.size() < FIFO_DEPTH);
        m_valid = 1'b0;
        if (e - m_last > CMD_GAP) begin
            if (m_q.size() > 0 && m_q[0].t >= 3'd3) begin
                if (!m_wrap && m_mode != 2'd2) begin
                    m_saved = m_mode;
                    m_wrap  = 1'b1;
                    model_issue(3'd2, 16'd0, e);
                end else begin
                    c = m_q.pop_front();
                    model_issue(c.t, c.d, e);
                end
            end else if (m_q.size() > 0) begin
                c = m_q.pop_front();
                m_wrap = 1'b0;
                model_issue(c.t, c.d, e);
            end else if (m_wrap) begin
                m_wrap = 1'b0;
                model_issue((m_saved == 2'd0) ? 3'd0 : 3'd1, 16'd0, e);
            end
        end
        if (v && ready) begin
            if (rule_ok(t, d)) begin
                c.t = t;
                c.d = d;
                m_q.push_back(c);
            end else if (m_drop != 8'd255) begin
                m_drop = m_drop + 8'd1;
            end
        end
        busy_m = (m_q.size() > 0) || m_wrap || (e - m_last < CMD_GAP);
        m_exp = {m_valid, m_cmd.t, m_cmd.d, m_mode, m_drop, (m_q.size() < FIFO_DEPTH), busy_m};
    endtask

    task automatic tick(input bit v, input logic [2:0] t, input logic [15:0] d);
        logic [31:0] act;
        cmd_t c;
        req_valid = v;
        req_type  = t;
        req_data  = d;
        model_step(v, t, d);
        @(posedge clk);
        #1;
        edge_n++;
        act = {cmd_valid, cmd_type, cmd_data, mode, drop_cnt, req_ready, busy};
        check($sformatf("cycle@%0d", edge_n), 64'(act), 64'(m_exp));
        if (cmd_valid) begin
            c.t = cmd_type;
            c.d = cmd_data;
            log_q.push_back(c);
            log_cyc.push_back(edge_n);
        end
    endtask

    task automatic async_reset();
        req_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_values",
              64'({cmd_valid, cmd_type, cmd_data, mode, drop_cnt, req_ready, busy}),
              64'({1'b0, 3'd0, 16'd0, 2'd0, 8'd0, 1'b1, 1'b0}));
        model_reset();
        @(posedge clk);
        #1;
        edge_n++;
        rst_n = 1'b1;
        #1;
        check("post_reset_ready_mode", 64'({req_ready, mode}), 64'({1'b1, 2'd0}));
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic push(input logic [2:0] t, input logic [15:0] d);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100 && !done; n++) begin
            done = req_ready;
            tick(1'b1, t, d);
            if (done) last_acc = edge_n;
        end
        check("push_accepted", 64'(done), 64'(1));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        tick(1'b0, 3'd0, 16'd0);
        while (busy && n < 300) begin
            tick(1'b0, 3'd0, 16'd0);
            n++;
        end
        check("idle_reached", 64'(busy), 64'(0));
    endtask

    task automatic expect_cmd(input logic [2:0] t, input logic [15:0] d);
        cmd_t c;
        c.t = t;
        c.d = d;
        exp_q.push_back(c);
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check($sformatf("%s_cmd%0d", name, i), 64'(log_q[i]), 64'(exp_q[i]));
            if (i > 0) begin
                check($sformatf("%s_gap%0d", name, i),
                      64'(log_cyc[i] - log_cyc[i-1] >= CMD_GAP + 1), 64'(1));
            end
        end
        exp_q.delete();
        log_q.delete();
        log_cyc.delete();
    endtask

    vec_t vecs[12];
    logic [2:0]  full_t[6];
    logic [15:0] full_d[6];

    initial begin
        int a0;
        logic [7:0] drop0;
        bit found;
        int n_acc;
        int full_at;
        int idx;
        int guard;
        bit r;

        vecs[0]  = '{3'd0, 16'd5,     1'b1};
        vecs[1]  = '{3'd7, 16'd3,     1'b0};
        vecs[2]  = '{3'd6, 16'd0,     1'b0};
        vecs[3]  = '{3'd3, 16'd0,     1'b0};
        vecs[4]  = '{3'd3, 16'd1,     1'b1};
        vecs[5]  = '{3'd4, 16'd1000,  1'b1};
        vecs[6]  = '{3'd4, 16'd1001,  1'b0};
        vecs[7]  = '{3'd5, 16'hFFFF,  1'b0};
        vecs[8]  = '{3'd2, 16'd123,   1'b1};
        vecs[9]  = '{3'd5, 16'd500,   1'b1};
        vecs[10] = '{3'd1, 16'd0,     1'b1};
        vecs[11] = '{3'd3, 16'd9,     1'b1};

        model_reset();
        async_reset();

        // Simple latency and spacing
        push(3'd0, 16'd5);
        a0 = last_acc;
        push(3'd1, 16'd7);
        wait_idle();
        check("simple_pulses", 64'(log_cyc.size()), 64'(2));
        if (log_cyc.size() >= 2) begin
            check("latency", 64'(log_cyc[0] - a0), 64'(1));
            check("spacing", 64'(log_cyc[1] - log_cyc[0] >= 3), 64'(1));
        end
        check("mode_off", 64'(mode), 64'(1));
        expect_cmd(3'd0, 16'd5);
        expect_cmd(3'd1, 16'd7);
        check_seq("simple");

        // Wrap from mode 1, then from mode 0
        push(3'd4, 16'd7); push(3'd5, 16'd3); push(3'd3, 16'd9);
        wait_idle();
        expect_cmd(3'd2, 16'd0); expect_cmd(3'd4, 16'd7); expect_cmd(3'd5, 16'd3);
        expect_cmd(3'd3, 16'd9); expect_cmd(3'd1, 16'd0);
        check_seq("wrap_m1");
        check("mode_after_wrap_m1", 64'(mode), 64'(1));
        push(3'd0, 16'd0);
        wait_idle();
        expect_cmd(3'd0, 16'd0);
        check_seq("to_normal");
        push(3'd4, 16'd7); push(3'd5, 16'd3); push(3'd3, 16'd9);
        wait_idle();
        expect_cmd(3'd2, 16'd0); expect_cmd(3'd4, 16'd7); expect_cmd(3'd5, 16'd3);
        expect_cmd(3'd3, 16'd9); expect_cmd(3'd0, 16'd0);
        check_seq("wrap_m0");
        check("mode_after_wrap_m0", 64'(mode), 64'(0));

        // Explicit mode inside a wrap cancels the auto-return
        push(3'd4, 16'd7); push(3'd1, 16'd0);
        wait_idle();
        expect_cmd(3'd2, 16'd0); expect_cmd(3'd4, 16'd7); expect_cmd(3'd1, 16'd0);
        check_seq("cancel");
        check("mode_after_cancel", 64'(mode), 64'(1));

        // Validation table
        for (int i = 0; i < 12; i++) begin
            drop0 = drop_cnt;
            log_q.delete();
            log_cyc.delete();
            push(vecs[i].t, vecs[i].d);
            wait_idle();
            check($sformatf("vec%0d_drop", i), 64'(drop_cnt - drop0), 64'(!vecs[i].ok));
            found = 1'b0;
            foreach (log_q[k]) begin
                if (log_q[k].t == vecs[i].t && log_q[k].d == vecs[i].d) found = 1'b1;
            end
            check($sformatf("vec%0d_issued", i), 64'(found), 64'(vecs[i].ok));
        end
        log_q.delete();
        log_cyc.delete();

        // Rejections around a wrapped sequence
        async_reset();
        push(3'd6, 16'd1); push(3'd3, 16'd0); push(3'd4, 16'd1001); push(3'd5, 16'd1000);
        wait_idle();
        check("drop_three", 64'(drop_cnt), 64'(3));
        expect_cmd(3'd2, 16'd0); expect_cmd(3'd5, 16'd1000); expect_cmd(3'd0, 16'd0);
        check_seq("reject");
        for (int i = 0; i < 300; i++) push(3'd6, 16'(i));
        wait_idle();
        check("drop_saturate", 64'(drop_cnt), 64'(255));

        // Full FIFO with valid held high
        async_reset();
        for (int i = 0; i < 6; i++) begin
            full_t[i] = 3'(3 + (i % 3));
            full_d[i] = 16'(10 + i);
        end
        n_acc = 0; full_at = -1; idx = 0; guard = 0;
        while (idx < 6 && guard < 100) begin
            r = req_ready;
            tick(1'b1, full_t[idx], full_d[idx]);
            if (r) begin idx++; n_acc++; end
            if (!req_ready && full_at < 0) full_at = n_acc;
            guard++;
        end
        check("full_all_accepted", 64'(n_acc), 64'(6));
        check("full_after_accepts", 64'(full_at), 64'(4));
        wait_idle();
        expect_cmd(3'd2, 16'd0);
        for (int i = 0; i < 6; i++) expect_cmd(full_t[i], full_d[i]);
        expect_cmd(3'd0, 16'd0);
        check_seq("full");

        // Reset while busy discards everything
        push(3'd4, 16'd100); push(3'd5, 16'd200); push(3'd3, 16'd300);
        for (int i = 0; i < 4; i++) tick(1'b0, 3'd0, 16'd0);
        async_reset();
        for (int i = 0; i < 20; i++) tick(1'b0, 3'd0, 16'd0);
        check("reset_busy_no_pulses", 64'(log_q.size()), 64'(0));
        check("reset_busy_idle", 64'(busy), 64'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [2:0]  rt;
            logic [15:0] rd;
            bit          rv;
            rv = ($urandom_range(0, 99) < 45);
            rt = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       rd = 16'd0;
                1:       rd = 16'(MAX_TIME);
                2:       rd = 16'(MAX_TIME + 1);
                3:       rd = 16'hFFFF;
                default: rd = 16'($urandom_range(1, MAX_TIME));
            endcase
            if ($urandom_range(0, 999) == 0) async_reset();
            else tick(rv, rt, rd);
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
